// File: rtl/vend_sequencer.sv
// Vending machine sequencer: accumulates coin credit in nickels, issues one vend
// pulse at the price, then pays change or refunds as paced nickel pulses.
module vend_sequencer #(
    parameter int unsigned PRICE      = 5,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned CHANGE_GAP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy
);

    localparam int unsigned GapW = $clog2(CHANGE_GAP + 1);

    localparam logic [CREDIT_W-1:0] PriceW = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CntOne = CREDIT_W'(1);
    localparam logic [GapW-1:0]     GapW0  = GapW'(CHANGE_GAP);
    localparam logic [GapW-1:0]     GapOne = GapW'(1);

    typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    // Change counter holds the nickels still owed after the pulse currently shown.
    logic [CREDIT_W-1:0] chg_cnt_q;
    // Gap counter holds the low cycles still to emit before the next pulse or exit.
    logic [GapW-1:0]     gap_q;
    logic                vend_q;
    logic                pulse_q;
    logic                reject_q;
    logic                busy_q;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_ok;
    logic [CREDIT_W-1:0] sum;

    // Decode the coin strobe into a nickel value and the candidate new credit.
    always_comb begin
        coin_val = '0;
        unique case (coin)
            2'b01:   coin_val = CREDIT_W'(1);
            2'b10:   coin_val = CREDIT_W'(2);
            2'b11:   coin_val = CREDIT_W'(5);
            default: coin_val = '0;
        endcase
        coin_ok = coin_valid && (coin != 2'b00);
        sum     = credit_q + coin_val;
    end

    // Single-process FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            credit_q  <= '0;
            chg_cnt_q <= '0;
            gap_q     <= '0;
            vend_q    <= 1'b0;
            pulse_q   <= 1'b0;
            reject_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            vend_q   <= 1'b0;
            pulse_q  <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cancel) begin
                        // Any coin arriving with a cancel is handed back.
                        reject_q <= coin_ok;
                        if (credit_q != '0) begin
                            state_q   <= StChange;
                            chg_cnt_q <= credit_q - CntOne;
                            credit_q  <= '0;
                            pulse_q   <= 1'b1;
                            gap_q     <= GapW0;
                            busy_q    <= 1'b1;
                        end
                    end else if (coin_ok) begin
                        if (sum >= PriceW) begin
                            state_q   <= StVend;
                            chg_cnt_q <= sum - PriceW;
                            credit_q  <= '0;
                            vend_q    <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            credit_q <= sum;
                        end
                    end
                end
                StVend: begin
                    reject_q <= coin_ok;
                    if (chg_cnt_q != '0) begin
                        state_q   <= StChange;
                        chg_cnt_q <= chg_cnt_q - CntOne;
                        pulse_q   <= 1'b1;
                        gap_q     <= GapW0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StChange: begin
                    reject_q <= coin_ok;
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GapOne;
                    end else if (chg_cnt_q != '0) begin
                        chg_cnt_q <= chg_cnt_q - CntOne;
                        pulse_q   <= 1'b1;
                        gap_q     <= GapW0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign credit       = credit_q;
    assign vend         = vend_q;
    assign change_pulse = pulse_q;
    assign coin_reject  = reject_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a vector table stepped one clock at a time,
// followed by a hand-written reset-during-payout sequence.
module tb_vend_sequencer;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin;
    logic       cancel;
    logic [3:0] credit;
    logic       vend;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;

    int n_tests;
    int n_fail;

    vend_sequencer #(
        .PRICE     (5),
        .CREDIT_W  (4),
        .CHANGE_GAP(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .cancel      (cancel),
        .credit      (credit),
        .vend        (vend),
        .change_pulse(change_pulse),
        .coin_reject (coin_reject),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [1:0] cn;
        logic       can;
        logic [3:0] e_credit;
        logic       e_vend;
        logic       e_pulse;
        logic       e_rej;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic cv, input logic [1:0] cn, input logic can,
                       input logic [3:0] ecr, input logic ev, input logic ep, input logic er,
                       input logic eb);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cn = cn; v.can = can;
        v.e_credit = ecr; v.e_vend = ev; v.e_pulse = ep; v.e_rej = er; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    // Drive inputs at the falling edge, sample outputs just after the rising edge.
    task automatic step(input logic rst, input logic cv, input logic [1:0] cn, input logic can);
        @(negedge clk);
        reset = rst; coin_valid = cv; coin = cn; cancel = can;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {credit,vend,pulse,rej,busy}=%h expected %h", name, act, exp);
        end
    endtask

    int pulses;
    int lat;
    logic seen;

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b0; coin_valid = 1'b0; coin = 2'b00; cancel = 1'b0;

        //   rst cv coin can | credit vend pulse rej busy
        add(1, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);  // reset
        add(0, 1, 2'b11, 0,  4'd0, 1, 0, 0, 1);  // quarter -> vend
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);  // no change, back to idle
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);
        add(0, 1, 2'b10, 0,  4'd2, 0, 0, 0, 0);  // dime
        add(0, 1, 2'b10, 0,  4'd4, 0, 0, 0, 0);  // dime
        add(0, 1, 2'b10, 0,  4'd0, 1, 0, 0, 1);  // dime -> 6, vend, change 1
        add(0, 0, 2'b00, 0,  4'd0, 0, 1, 0, 1);  // first change pulse
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);  // gap
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);  // gap
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);  // idle
        add(0, 1, 2'b01, 0,  4'd1, 0, 0, 0, 0);  // nickel
        add(0, 1, 2'b10, 0,  4'd3, 0, 0, 0, 0);  // dime
        add(0, 0, 2'b00, 1,  4'd0, 0, 1, 0, 1);  // cancel -> refund 3
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);
        add(0, 1, 2'b10, 0,  4'd2, 0, 0, 0, 0);  // dime
        add(0, 1, 2'b11, 0,  4'd0, 1, 0, 0, 1);  // quarter -> 7, vend, change 2
        add(0, 1, 2'b01, 0,  4'd0, 0, 1, 1, 1);  // nickel during vend rejected
        add(0, 1, 2'b11, 0,  4'd0, 0, 0, 1, 1);  // quarter during change rejected
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 1, 0, 1);  // second pulse
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);
        add(0, 1, 2'b10, 0,  4'd2, 0, 0, 0, 0);  // dime
        add(0, 1, 2'b01, 1,  4'd0, 0, 1, 1, 1);  // cancel + nickel: refund 2, reject
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);
        add(0, 1, 2'b00, 0,  4'd0, 0, 0, 0, 0);  // coin 00 ignored
        add(0, 1, 2'b01, 0,  4'd1, 0, 0, 0, 0);  // nickel
        add(0, 1, 2'b00, 0,  4'd1, 0, 0, 0, 0);  // coin 00 ignored
        add(0, 0, 2'b00, 1,  4'd0, 0, 1, 0, 1);  // cancel at credit 1
        add(0, 0, 2'b00, 1,  4'd0, 0, 0, 0, 1);  // cancel ignored while busy
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);
        add(0, 1, 2'b11, 1,  4'd0, 0, 0, 1, 0);  // cancel at credit 0 rejects coin
        add(0, 0, 2'b00, 0,  4'd0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].cv, vecs[i].cn, vecs[i].can);
            check($sformatf("vec%0d", i),
                  {credit, vend, change_pulse, coin_reject, busy},
                  {vecs[i].e_credit, vecs[i].e_vend, vecs[i].e_pulse, vecs[i].e_rej,
                   vecs[i].e_busy});
        end

        // Reset in the middle of a 3-nickel refund, right after the first pulse.
        step(0, 1, 2'b01, 0);
        step(0, 1, 2'b10, 0);
        step(0, 0, 2'b00, 1);
        check("refund_first_pulse", {credit, vend, change_pulse, coin_reject, busy},
              {4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        step(0, 0, 2'b00, 0);
        step(1, 0, 2'b00, 0);
        check("reset_mid_change", {credit, vend, change_pulse, coin_reject, busy}, 8'h00);
        pulses = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'b00, 0);
            if (change_pulse) pulses++;
            if (busy) seen = 1'b1;
        end
        check("no_pulses_after_reset", 8'(pulses), 8'd0);
        check("idle_after_reset", {7'd0, seen}, 8'd0);

        // A quarter must vend exactly one cycle after its strobe.
        step(0, 1, 2'b11, 0);
        lat = 1;
        while (!vend && lat < 5) begin
            step(0, 0, 2'b00, 0);
            lat++;
        end
        check("quarter_vend_latency", 8'(lat), 8'd1);
        step(0, 0, 2'b00, 0);
        check("post_vend_idle", {credit, vend, change_pulse, coin_reject, busy}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Registered controller for the vending machine. It accepts encoded coin strobes and accumulates credit in nickel units.
- When credit reaches the price, it issues a single vend pulse, then pays out change as paced nickel pulses.
- It also handles a cancel/refund request.
- It sits between the coin-acceptor decode and the dispense/change actuators, and owns the credit register.

Parameters:
- PRICE, 5, item price in nickels (5 = 25 cents); legal range 1..(2^CREDIT_W - 5).
- CREDIT_W, 4, width of credit and change registers; must hold PRICE+4.
- CHANGE_GAP, 2, low cycles between consecutive change_pulse highs; legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- coin_valid  input  1  one-cycle strobe; coin is sampled when high.
- coin  input  2  encoded coin: 00 none (ignored even if valid), 01 nickel = 1, 10 dime = 2, 11 quarter = 5.
- cancel  input  1  refund request, level-sampled each cycle.
- credit  output  CREDIT_W  current accumulated credit in nickels.
- vend  output  1  one-cycle dispense command.
- change_pulse  output  1  one-cycle pulse per nickel of change/refund.
- coin_reject  output  1  one-cycle pulse; the sampled coin was not accepted and must be returned.
- busy  output  1  high in VEND and CHANGE states.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On any rising edge with reset=1:
  - state=IDLE, credit=0, vend=0, change_pulse=0, coin_reject=0, busy=0, change counter=0, gap counter=0.
  - Reset overrides everything, including mid-payout: remaining change is discarded.
- All outputs are registered. Response to an input sampled at edge k is visible in the cycle after edge k.

States:
- IDLE: accumulate credit (credit may be nonzero).
- VEND: exactly one cycle.
- CHANGE: pay out until the change counter reaches 0.

IDLE, per edge, priority order:
1. cancel=1 and credit>0:
   - change counter = credit; credit = 0; go to CHANGE.
   - A simultaneous valid coin is rejected (coin_reject=1).
2. cancel=1 and credit=0: no action. A simultaneous valid coin is rejected.
3. coin_valid=1, coin≠00: credit = credit + value.
   - If the new credit ≥ PRICE: go to VEND; change counter = new credit − PRICE; credit = 0.
   - Otherwise stay in IDLE.
   - Overflow is impossible by parameter constraint (max pre-coin credit PRICE−1, plus 5).
4. coin_valid=1, coin=00: ignored; no reject.

VEND:
- vend=1 and busy=1 for exactly one cycle.
- Next state: CHANGE if change counter > 0, else IDLE.

CHANGE:
- First change_pulse is asserted in the cycle immediately after entry.
- Each pulse decrements the change counter. Each pulse is followed by CHANGE_GAP low cycles before the next.
- After the last pulse plus its gap, return to IDLE.
- Exactly N pulses are issued for N nickels.

Busy handling:
- Any valid non-00 coin sampled in VEND or CHANGE gives coin_reject=1 the following cycle, with credit unchanged.
- cancel is ignored in VEND and CHANGE.

credit output:
- Reflects the register. It reads 0 from the cycle vend asserts, and from the first cycle of a refund payout.

Arithmetic:
- Unsigned, CREDIT_W bits.
- Comparisons and subtraction are done at CREDIT_W width; no wrap can occur under legal parameters.

Test Plan:
- Reset, then quarter (11) → credit 5 triggers a vend pulse the cycle after the strobe; no change_pulse; back to IDLE with credit=0.
- Dime, dime, dime (PRICE=5) → credit 2, 4, then vend with change 1 → one change_pulse 1 cycle after vend; busy returns low after the gap.
- Nickel + dime, then cancel → 3 change_pulses, each separated by exactly CHANGE_GAP=2 low cycles; credit=0; vend never asserted.
- Dime + quarter → vend, then 2 change pulses. A quarter strobed during CHANGE → coin_reject one cycle later; credit stays 0; pulse count is still 2.
- Same-cycle cancel and nickel at credit=2 → refund of 2; coin_reject=1; credit stays 0. Coin 00 with coin_valid → no state change, no reject.
- Assert reset mid-CHANGE after 1 of 3 pulses → next cycle all outputs 0, state IDLE, no further pulses. Then a quarter vends normally.
